// File: rtl/print_compare_pkg.sv
// Shared definitions for the print compare / hammer-fire block.
package print_compare_pkg;

    localparam int PCG_W         = 6;
    localparam int DEF_POSITIONS = 132;
    localparam int DEF_SUBSCANS  = 3;

    localparam logic [PCG_W-1:0] PCG_BLANK = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_blank(input logic [PCG_W-1:0] code);
        return code == PCG_BLANK;
    endfunction

endpackage

// File: rtl/print_compare_if.sv
// Print line buffer read bus: the compare block is master, the buffer is slave.
interface print_compare_if #(
    parameter int ADDR_W = 8
) ();
    import print_compare_pkg::*;

    logic              o_buf_rd;
    logic [ADDR_W-1:0] o_buf_addr;
    logic [PCG_W-1:0]  i_buf_data;

    modport master (
        output o_buf_rd,
        output o_buf_addr,
        input  i_buf_data
    );

    modport slave (
        input  o_buf_rd,
        input  o_buf_addr,
        output i_buf_data
    );
endinterface

// File: rtl/print_compare_edge_detect.sv
// Level-to-pulse converter: one-cycle pulse on each rising edge of i_level.
module print_compare_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);
    logic r_last;

    // Remember last cycle's level every clock.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_last <= 1'b0;
        else         r_last <= i_level;
    end

    assign o_pulse = i_level & ~r_last;
endmodule

// File: rtl/print_compare.sv
// Print compare: scans one interleaved subscan of the line buffer per chain
// subscan, fires each hammer once when its character meets the PCG code.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no line in progress; waiting for a start edge
// ARMED    | line open, waiting for the next subscan edge
// SCAN     | issuing one buffer read per cycle for the current subscan
// DRAIN    | final compare of the subscan, then decide line end
// DONE     | line fully printed; o_line_done pulse
module print_compare
    import print_compare_pkg::*;
#(
    parameter int POSITIONS    = DEF_POSITIONS,
    parameter int SUBSCANS     = DEF_SUBSCANS,
    parameter int ADDR_W       = 8,
    parameter int MAX_SUBSCANS = 1440
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start_line,
    input  logic              i_subscan,
    input  logic [1:0]        i_subscan_id,
    input  logic [PCG_W-1:0]  i_pcg,
    print_compare_if.master   bus,
    output logic              o_fire,
    output logic [ADDR_W-1:0] o_fire_pos,
    output logic              o_busy,
    output logic              o_line_done,
    output logic              o_print_check,
    output logic              o_overrun
);
    localparam int CNT_W = $clog2(MAX_SUBSCANS + 1);
    localparam logic [ADDR_W:0]  LP_SUB = SUBSCANS[ADDR_W:0];
    localparam logic [ADDR_W:0]  LP_POS = POSITIONS[ADDR_W:0];
    localparam logic [CNT_W-1:0] LP_MAX = MAX_SUBSCANS[CNT_W-1:0];

    state_t                 r_state, w_state_nxt;
    logic [ADDR_W-1:0]      r_pos;
    logic [PCG_W-1:0]       r_pcg;
    logic [CNT_W-1:0]       r_count;
    logic [POSITIONS-1:0]   r_mask;
    logic                   r_cmp_valid;
    logic [ADDR_W-1:0]      r_cmp_addr;
    logic                   r_print_check;
    logic                   r_overrun;

    logic                   w_start_edge, w_sub_edge;
    logic                   w_id_ok;
    logic [ADDR_W:0]        w_pos_nxt;
    logic                   w_last_issue;
    logic                   w_cmp_act, w_cmp_blank, w_cmp_match;
    logic                   w_fire, w_set;
    logic [POSITIONS-1:0]   w_mask_next;
    logic                   w_all_done;
    logic                   w_clear_line, w_accept, w_issue, w_set_pc, w_set_ovr;

    print_compare_edge_detect u_start_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_level (i_start_line),
        .o_pulse (w_start_edge)
    );

    print_compare_edge_detect u_subscan_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_level (i_subscan),
        .o_pulse (w_sub_edge)
    );

    assign w_id_ok      = {{(ADDR_W-1){1'b0}}, i_subscan_id} < LP_SUB;
    assign w_pos_nxt    = {1'b0, r_pos} + LP_SUB;
    assign w_last_issue = w_pos_nxt >= LP_POS;

    // Compare stage runs on the data returned for last cycle's read.
    assign w_cmp_act   = r_cmp_valid & ~r_mask[r_cmp_addr];
    assign w_cmp_blank = is_blank(bus.i_buf_data);
    assign w_cmp_match = bus.i_buf_data == r_pcg;
    assign w_fire      = w_cmp_act & ~w_cmp_blank & w_cmp_match;
    assign w_set       = w_cmp_act & (w_cmp_blank | w_cmp_match);

    // Printed mask including this cycle's compare, so DRAIN sees the last result.
    always_comb begin
        w_mask_next = r_mask;
        if (w_set) w_mask_next[r_cmp_addr] = 1'b1;
    end

    assign w_all_done = &w_mask_next;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_clear_line = 1'b0;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_set_pc     = 1'b0;
        w_set_ovr    = 1'b0;
        o_busy       = 1'b1;
        o_line_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_start_edge) begin
                    w_clear_line = 1'b1;
                    w_state_nxt  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_sub_edge && w_id_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_issue   = 1'b1;
                w_set_ovr = w_sub_edge;
                if (w_last_issue) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_set_ovr = w_sub_edge;
                if (w_all_done) begin
                    w_state_nxt = ST_DONE;
                end else if (r_count == LP_MAX) begin
                    w_set_pc    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_DONE: begin
                o_line_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                o_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line context, scan pointer, compare pipeline and sticky flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pos         <= '0;
            r_pcg         <= '0;
            r_count       <= '0;
            r_mask        <= '0;
            r_cmp_valid   <= 1'b0;
            r_cmp_addr    <= '0;
            r_print_check <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_clear_line) begin
                r_mask        <= '0;
                r_count       <= '0;
                r_print_check <= 1'b0;
                r_overrun     <= 1'b0;
            end else begin
                r_mask <= w_mask_next;
                if (w_set_pc)  r_print_check <= 1'b1;
                if (w_set_ovr) r_overrun     <= 1'b1;
                if (w_accept)  r_count       <= r_count + 1'b1;
            end
            if (w_accept) begin
                r_pcg <= i_pcg;
                r_pos <= {{(ADDR_W-2){1'b0}}, i_subscan_id};
            end else if (w_issue) begin
                r_pos <= w_pos_nxt[ADDR_W-1:0];
            end
            r_cmp_valid <= w_issue;
            if (w_issue) r_cmp_addr <= r_pos;
        end
    end

    assign bus.o_buf_rd   = w_issue;
    assign bus.o_buf_addr = w_issue ? r_pos : '0;
    assign o_fire         = w_fire;
    assign o_fire_pos     = w_fire ? r_cmp_addr : '0;
    assign o_print_check  = r_print_check;
    assign o_overrun      = r_overrun;
endmodule

// File: tb/tb_print_compare.sv
module tb_print_compare;
    import print_compare_pkg::*;

    localparam int POS  = 132;
    localparam int SUB  = 3;
    localparam int AW   = 8;
    localparam int MAXS = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_line, subscan;
    logic [1:0]        subscan_id;
    logic [5:0]        pcg;
    logic              fire, busy, line_done, print_check, overrun;
    logic [AW-1:0]     fire_pos;

    always #5 clk = ~clk;

    print_compare_if #(.ADDR_W(AW)) bus ();

    print_compare #(
        .POSITIONS(POS), .SUBSCANS(SUB), .ADDR_W(AW), .MAX_SUBSCANS(MAXS)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start_line(start_line),
        .i_subscan(subscan), .i_subscan_id(subscan_id), .i_pcg(pcg),
        .bus(bus), .o_fire(fire), .o_fire_pos(fire_pos), .o_busy(busy),
        .o_line_done(line_done), .o_print_check(print_check), .o_overrun(overrun)
    );

    // Line buffer model: data valid the cycle after the read strobe, junk otherwise.
    logic [5:0] buf_mem [POS];
    always @(posedge clk)
        bus.i_buf_data <= bus.o_buf_rd ? buf_mem[bus.o_buf_addr] : 6'h3f;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model state
    int  exp_reads[$];
    int  exp_fires[$];
    bit  ref_mask[POS];
    bit  ref_armed = 0;
    int  ref_count = 0;
    int  exp_done = 0;
    int  exp_pc = 0;
    int  n_done = 0;

    // Monitor
    int  cyc = 0;
    int  last_read_cyc = -100;
    int  prev_read_addr = -1;
    bit  done_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (done_prev) begin
            chk("busy_after_done", int'(busy), 0);
            done_prev = 0;
        end
        if (fire) begin
            if (exp_fires.size() == 0) chk("unexpected_fire", int'(fire_pos), -1);
            else chk("fire_pos", int'(fire_pos), exp_fires.pop_front());
            chk("fire_latency", int'(fire_pos), prev_read_addr);
        end
        if (line_done) begin
            n_done++;
            chk("done_latency", cyc - last_read_cyc, 2);
            done_prev = 1;
        end
        if (bus.o_buf_rd) begin
            if (exp_reads.size() == 0) chk("unexpected_read", int'(bus.o_buf_addr), -1);
            else chk("read_addr", int'(bus.o_buf_addr), exp_reads.pop_front());
            prev_read_addr = int'(bus.o_buf_addr);
            last_read_cyc  = cyc;
        end else begin
            prev_read_addr = -1;
        end
    end

    function automatic bit line_full();
        for (int p = 0; p < POS; p++) if (!ref_mask[p]) return 0;
        return 1;
    endfunction

    // Expected behaviour of one subscan, straight from the print rules.
    task automatic model_subscan(input int id, input logic [5:0] code);
        if (!ref_armed || id >= SUB) return;
        ref_count++;
        for (int p = id; p < POS; p += SUB) begin
            exp_reads.push_back(p);
            if (!ref_mask[p]) begin
                if (buf_mem[p] == 6'o00) ref_mask[p] = 1;
                else if (buf_mem[p] == code) begin
                    exp_fires.push_back(p);
                    ref_mask[p] = 1;
                end
            end
        end
        if (line_full()) begin
            exp_done++;
            ref_armed = 0;
        end else if (ref_count == MAXS) begin
            exp_pc = 1;
            ref_armed = 0;
        end
    endtask

    task automatic pulse_subscan(input int id, input logic [5:0] code);
        @(posedge clk); #2;
        subscan_id = 2'(id);
        pcg        = code;
        subscan    = 1'b1;
        @(posedge clk); #2;
        subscan    = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((exp_reads.size() != 0 || exp_fires.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("scan_timeout", exp_reads.size() + exp_fires.size(), 0);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic do_subscan(input int id, input logic [5:0] code);
        model_subscan(id, code);
        pulse_subscan(id, code);
        wait_quiet();
        chk("busy", int'(busy), int'(ref_armed));
        chk("line_done_count", n_done, exp_done);
        chk("print_check", int'(print_check), exp_pc);
    endtask

    task automatic do_start();
        @(posedge clk); #2;
        start_line = 1'b1;
        @(posedge clk); #2;
        start_line = 1'b0;
        ref_armed = 1;
        ref_count = 0;
        exp_pc    = 0;
        for (int p = 0; p < POS; p++) ref_mask[p] = 0;
        chk("busy_armed", int'(busy), 1);
        chk("sticky_pc_cleared", int'(print_check), 0);
        chk("sticky_ovr_cleared", int'(overrun), 0);
    endtask

    task automatic fill(input logic [5:0] code);
        for (int p = 0; p < POS; p++) buf_mem[p] = code;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] codes [3];
        codes[0] = 6'o01; codes[1] = 6'o21; codes[2] = 6'o07;
        rst = 1'b1; start_line = 0; subscan = 0; subscan_id = 0; pcg = 0;
        fill(6'o00);
        #12;
        chk("rst_fire", int'(fire), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(line_done), 0);
        chk("rst_rd", int'(bus.o_buf_rd), 0);
        chk("rst_pc", int'(print_check), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // subscan while idle is ignored
        do_subscan(0, 6'o01);

        // all blank line
        do_start();
        for (int k = 0; k < 3; k++) do_subscan(k, 6'o21);

        // single position, matched once only
        fill(6'o00);
        buf_mem[5] = 6'o21;
        do_start();
        do_subscan(2, 6'o21);
        do_subscan(2, 6'o21);
        do_subscan(0, 6'o21);
        do_subscan(1, 6'o21);

        // two fires on consecutive cycles; id 3 ignored in ARMED
        fill(6'o00);
        buf_mem[0] = 6'o01;
        buf_mem[3] = 6'o01;
        do_start();
        do_subscan(3, 6'o01);
        do_subscan(0, 6'o01);
        do_subscan(1, 6'o01);
        do_subscan(2, 6'o01);

        // print check timeout
        fill(6'o00);
        buf_mem[7] = 6'o21;
        do_start();
        for (int k = 0; k < MAXS; k++) do_subscan(k % SUB, 6'o01);
        do_subscan(1, 6'o21);

        // overrun: second edge 10 cycles into the scan is dropped
        fill(6'o00);
        do_start();
        model_subscan(0, 6'o01);
        pulse_subscan(0, 6'o01);
        repeat (8) @(posedge clk);
        #2;
        subscan_id = 2'd1;
        subscan    = 1'b1;
        @(posedge clk); #2;
        subscan    = 1'b0;
        wait_quiet();
        chk("overrun", int'(overrun), 1);
        chk("busy_after_overrun", int'(busy), 1);
        do_subscan(1, 6'o01);
        chk("overrun_sticky", int'(overrun), 1);
        do_subscan(2, 6'o01);

        // reset in the middle of a firing scan
        fill(6'o07);
        do_start();
        model_subscan(0, 6'o07);
        pulse_subscan(0, 6'o07);
        begin
            int n = 0;
            while (!fire && n < 50) begin
                @(posedge clk); #2;
                n++;
            end
            chk("fire_before_reset", int'(fire), 1);
        end
        rst = 1'b1;
        #1;
        chk("async_fire", int'(fire), 0);
        chk("async_rd", int'(bus.o_buf_rd), 0);
        chk("async_busy", int'(busy), 0);
        exp_reads.delete();
        exp_fires.delete();
        ref_armed = 0;
        prev_read_addr = -1;
        @(posedge clk); #2;
        rst = 1'b0;

        // clean restart: every position must fire again
        do_start();
        for (int k = 0; k < 3; k++) do_subscan(k, 6'o07);

        // randomized lines
        for (int line = 0; line < 6; line++) begin
            for (int p = 0; p < POS; p++)
                buf_mem[p] = ($urandom_range(0, 9) < 8) ? 6'o00 : codes[$urandom_range(0, 2)];
            do_start();
            for (int it = 0; it < 40 && ref_armed; it++)
                do_subscan($urandom_range(0, 3), codes[$urandom_range(0, 2)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/print_compare.md
Name: print_compare

Overview:
- Consumer of the 6-bit print character generator (PCG) code: the compare/hammer-fire end of the 1403 print path in the 2821 model.
- On each print subscan, reads every position of that subscan from the print line buffer and compares it with the current PCG code.
- On a match, fires the hammer for that position once.
- Tracks which positions are already printed; ends the line when all are printed or on a print-check timeout.

Parameters:
- POSITIONS, 132, print positions per line; buffer addresses 0..POSITIONS-1.
- SUBSCANS, 3, interleave factor; subscan k covers positions k, k+SUBSCANS, k+2*SUBSCANS, ...
- ADDR_W, 8, buffer address width.
- MAX_SUBSCANS, 1440, subscans allowed per line before print check.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start_line  in  1  level; a rising edge arms a new line.
- i_subscan  in  1  level from chain timing; a rising edge starts one subscan.
- i_subscan_id  in  2  subscan index 0..SUBSCANS-1; sampled on the subscan edge.
- i_pcg  in  6  PCG code {b,a,8,4,2,1}; sampled on the subscan edge.
- o_buf_rd  out  1  buffer read strobe.
- o_buf_addr  out  ADDR_W  buffer read address.
- i_buf_data  in  6  buffer data; valid the cycle after o_buf_rd.
- o_fire  out  1  one-cycle hammer-fire pulse.
- o_fire_pos  out  ADDR_W  position being fired; valid while o_fire.
- o_busy  out  1  line in progress.
- o_line_done  out  1  one-cycle pulse at successful line end.
- o_print_check  out  1  sticky; timeout occurred.
- o_overrun  out  1  sticky; subscan edge arrived while a scan was still running.

Behaviour:
- Reset (async): all outputs 0, state IDLE, printed mask cleared, counters 0, edge-detect registers 0.
- Edge detection: last_* registers update every clock; edge = level & ~last. An edge is acted on the cycle it is seen.
- States: IDLE, ARMED, SCAN, DRAIN, DONE.
- IDLE:
  - Start edge -> clear mask, clear subscan count, clear both sticky flags -> ARMED.
  - Subscan edges are ignored.
- ARMED:
  - Subscan edge with id < SUBSCANS -> latch pcg and id, set pos = id, increment subscan count -> SCAN.
  - Subscan edge with id >= SUBSCANS -> ignored.
  - Start edge in ARMED or SCAN -> ignored.
- SCAN:
  - Each cycle: o_buf_rd = 1, o_buf_addr = pos, pos += SUBSCANS.
  - When pos + SUBSCANS >= POSITIONS after the issue -> DRAIN.
  - A subscan of 44 positions takes 44 SCAN cycles.
- Compare stage, one cycle after each read, for address a:
  - If mask[a] is set: no action.
  - Else if data == 6'b000000 (blank): set mask[a], no fire.
  - Else if data == latched pcg: o_fire = 1, o_fire_pos = a, set mask[a].
  - Net fire latency is read strobe + 1 cycle.
- DRAIN: one cycle for the final compare, then:
  - If all POSITIONS mask bits are set -> DONE.
  - Else if subscan count == MAX_SUBSCANS -> set o_print_check -> IDLE.
  - Else -> ARMED.
- DONE: o_line_done = 1 for one cycle -> IDLE.
- o_busy = 1 in ARMED, SCAN, DRAIN and DONE.
- Overrun: a subscan edge seen in SCAN or DRAIN sets o_overrun and is dropped; the current scan completes.
- Each position fires at most once per line, even if the chain presents the same code again.
- Sticky flags clear only on reset or a new start edge.
- Reset mid-scan: immediate return to IDLE, with o_fire and o_buf_rd deasserted asynchronously.

Decomposition:
- Shared package (pcg_pkg): PCG code width (6), blank code constant, state encoding, default POSITIONS/SUBSCANS.
- One natural sub-module: edge_detect (level-to-pulse, one register). Reusable for the PCG advance inputs.

Test Plan:
- Reset, start; buffer all blank; subscans id 0, 1, 2 -> no o_fire; o_line_done pulses 2 cycles after the last id-2 read; o_busy falls the next cycle.
- Position 5 = 6'o21, the rest blank; subscan id 2 with pcg 6'o21 -> single o_fire, o_fire_pos = 5, 1 cycle after the read of address 5; the next matching subscan id 2 -> no fire.
- Positions 0 and 3 both = 6'o01; subscan id 0 with pcg 6'o01 -> two fires, pos 0 then pos 3, on consecutive cycles.
- MAX_SUBSCANS = 6; one position never matches -> o_print_check = 1 after the 6th subscan; state IDLE; o_line_done stays 0.
- Subscan edge 10 cycles into a scan -> o_overrun = 1; that scan still issues all 44 reads; the dropped subscan produces no reads.
- Assert i_reset during SCAN -> o_fire, o_buf_rd and o_busy drop without a clock edge; the next start edge resumes cleanly with an empty mask.
